// File: rtl/m_fetch_pkg.sv
// ---------------------------------------------------------------------------
// m_fetch_pkg : shared types for the fetch queue (state, word index, entry)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package m_fetch_pkg;

   typedef logic [31:0] word_idx_t;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_CAPTURE = 3'd2,
      S_FULL    = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   typedef struct packed {
      logic [31:0] instruction;
      word_idx_t   pc;
   } entry_t;

endpackage

`default_nettype wire

// File: rtl/m_fetch_fifo.sv
// ---------------------------------------------------------------------------
// m_fetch_fifo : DEPTH-entry synchronous FIFO with flush and registered head
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module m_fetch_fifo
   import m_fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   flush,
   input  logic   push,
   input  entry_t push_data,
   input  logic   pop,
   output entry_t head,
   output logic   valid,
   output logic   full
);

   localparam int AW = $clog2(DEPTH);

   entry_t         mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    count;
   logic           do_push;
   logic           do_pop;
   logic [AW-1:0]  rd_next;
   logic [AW:0]    count_after_pop;

   assign valid           = (count != '0);
   assign full            = (count == (AW+1)'(DEPTH));
   assign do_pop          = pop && valid && !flush;
   assign do_push         = push && !flush && (!full || do_pop);
   assign rd_next         = rd_ptr + AW'(do_pop);
   assign count_after_pop = count - (AW+1)'(do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Head is re-registered every cycle; a push into an otherwise empty
   // queue bypasses storage so it is visible the very next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(do_push);
         rd_ptr <= rd_next;
         count  <= count_after_pop + (AW+1)'(do_push);
         if (do_push && count_after_pop == '0) head <= push_data;
         else                                  head <= mem[rd_next];
      end
   end

endmodule

`default_nettype wire

// File: rtl/m_fetch_queue.sv
// ---------------------------------------------------------------------------
// m_fetch_queue : fetch FSM driving the decompressor pc into a small queue
// Optional: FETCH_STATS_EN adds fetch_count_o push counter.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module m_fetch_queue
   import m_fetch_pkg::*;
#(
   parameter int          DEPTH  = 4,
   parameter logic [31:0] PC_MAX = 32'd400
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable_i,
   output logic [31:0] pc,
   input  logic [31:0] instruction,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
`ifdef FETCH_STATS_EN
   output logic [31:0] fetch_count_o,
`endif
   output logic        done_o
);

   state_t    state;
   state_t    state_n;
   word_idx_t pc_q;
   word_idx_t pc_n;
   logic      push;
   logic      pop;
   logic      full;
   entry_t    head;
   entry_t    push_data;

   assign pc            = pc_q;
   assign pop           = instr_valid_o && instr_ready_i && !redirect_i;
   assign push_data     = '{instruction: instruction, pc: pc_q};
   assign instr_o       = head.instruction;
   assign instr_pc_o    = head.pc;
   assign done_o        = (state == S_DONE);

   m_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_i),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .valid     (instr_valid_o),
      .full      (full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         pc_q  <= '0;
      end else begin
         state <= state_n;
         pc_q  <= pc_n;
      end
   end

   always_comb begin
      state_n = state;
      pc_n    = pc_q;
      push    = 1'b0;
      if (redirect_i) begin
         state_n = S_ISSUE;
         pc_n    = (redirect_pc_i > PC_MAX) ? PC_MAX : redirect_pc_i;
      end else begin
         case (state)
            S_IDLE:  if (enable_i) state_n = S_ISSUE;
            S_ISSUE: state_n = S_CAPTURE;
            S_CAPTURE, S_FULL: begin
               // A pop in the same cycle frees the slot we are writing.
               if (!full || pop) begin
                  push = 1'b1;
                  if (pc_q == PC_MAX) begin
                     state_n = S_DONE;
                  end else begin
                     pc_n    = pc_q + 32'd1;
                     state_n = enable_i ? S_ISSUE : S_IDLE;
                  end
               end else begin
                  state_n = S_FULL;
               end
            end
            S_DONE:  state_n = S_DONE;
            default: state_n = S_IDLE;
         endcase
      end
   end

`ifdef FETCH_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                   fetch_count_o <= '0;
      else if (redirect_i)                          fetch_count_o <= '0;
      else if (push && fetch_count_o != 32'hFFFF_FFFF) fetch_count_o <= fetch_count_o + 32'd1;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_m_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_m_fetch_queue : scoreboard bench for m_fetch_queue (DEPTH=4, PC_MAX=24)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_m_fetch_queue;
   import m_fetch_pkg::*;

   localparam int          DEPTH  = 4;
   localparam logic [31:0] PC_MAX = 32'd24;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable_i;
   logic [31:0] pc;
   logic [31:0] instruction;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic        done_o;
`ifdef FETCH_STATS_EN
   logic [31:0] fetch_count_o;
`endif

   int     n_chk = 0;
   int     n_err = 0;
   int     cyc   = 0;
   entry_t sb[$];
   int     pop_cyc[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // decompressor model
   assign instruction = 32'hA000_0000 + pc;

   m_fetch_queue #(.DEPTH(DEPTH), .PC_MAX(PC_MAX)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable_i      (enable_i),
      .pc            (pc),
      .instruction   (instruction),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .instr_o       (instr_o),
      .instr_pc_o    (instr_pc_o),
      .instr_valid_o (instr_valid_o),
      .instr_ready_i (instr_ready_i),
`ifdef FETCH_STATS_EN
      .fetch_count_o (fetch_count_o),
`endif
      .done_o        (done_o)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Expected stream after a (re)start at 'from': every word up to PC_MAX.
   task automatic expect_run(input logic [31:0] from);
      entry_t e;
      sb.delete();
      for (int p = int'(from); p <= int'(PC_MAX); p++) begin
         e.instruction = 32'hA000_0000 + 32'(p);
         e.pc          = 32'(p);
         sb.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && instr_valid_o && instr_ready_i && !redirect_i) begin
         entry_t e;
         check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("instr", instr_o, e.instruction);
            check("tag", instr_pc_o, e.pc);
         end
         pop_cyc.push_back(cyc);
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_done_drain(input string tag, input int budget);
      for (int k = 0; k < budget; k++) begin
         if (done_o && sb.size() == 0 && !instr_valid_o) break;
         @(negedge clk);
      end
      check({tag, "_done"}, 32'(done_o), 32'd1);
      check({tag, "_drained"}, 32'(sb.size()), 32'd0);
   endtask

   task automatic redirect_to(input logic [31:0] target, input logic [31:0] from, input logic rdy);
      @(posedge clk); #1;
      redirect_i    = 1'b1;
      redirect_pc_i = target;
      instr_ready_i = rdy;
      expect_run(from);
      @(posedge clk); #1;
      redirect_i    = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; enable_i = 1'b0; redirect_i = 1'b0;
      redirect_pc_i = '0; instr_ready_i = 1'b0;
      #3;
      check("rst_pc", pc, 32'd0);
      check("rst_valid", 32'(instr_valid_o), 32'd0);
      check("rst_instr", instr_o, 32'd0);
      check("rst_tag", instr_pc_o, 32'd0);
      check("rst_done", 32'(done_o), 32'd0);

      // free run from reset, one entry every two cycles
      @(posedge clk); #1;
      rst_n = 1'b1; enable_i = 1'b1; instr_ready_i = 1'b1;
      expect_run(32'd0);
      for (int k = 0; k < 40 && pop_cyc.size() < 3; k++) @(negedge clk);
      check("t1_pops", 32'(pop_cyc.size() >= 3), 32'd1);
      if (pop_cyc.size() >= 3) begin
         check("t1_gap1", 32'(pop_cyc[1] - pop_cyc[0]), 32'd2);
         check("t1_gap2", 32'(pop_cyc[2] - pop_cyc[1]), 32'd2);
      end
      wait_done_drain("t1", 200);
      check("t1_pc_max", pc, PC_MAX);
`ifdef FETCH_STATS_EN
      check("t1_stats", fetch_count_o, 32'd25);
`endif
      wait_cycles(8);
      check("t1_no_push_done", 32'(instr_valid_o), 32'd0);

      // redirect out of done
      redirect_to(32'd2, 32'd2, 1'b1);
      check("t5_done_clr", 32'(done_o), 32'd0);
      check("t5_pc", pc, 32'd2);
      wait_done_drain("t5", 200);

      // back-pressure fills the queue
      @(posedge clk); #1;
      rst_n = 1'b0; instr_ready_i = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      expect_run(32'd0);
      wait_cycles(20);
      check("t2_pc_hold", pc, 32'd4);
      check("t2_valid", 32'(instr_valid_o), 32'd1);
      check("t2_head", instr_pc_o, 32'd0);
      wait_cycles(3);
      check("t2_pc_hold2", pc, 32'd4);
      @(posedge clk); #1;
      instr_ready_i = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         if (pc == 32'd5) break;
      end
      check("t2_pc_adv", pc, 32'd5);

      // redirect while full with ready high: flush wins
      @(posedge clk); #1;
      instr_ready_i = 1'b0;
      wait_cycles(20);
      check("t3_full_valid", 32'(instr_valid_o), 32'd1);
      redirect_to(32'd20, 32'd20, 1'b1);
      check("t3_flushed", 32'(instr_valid_o), 32'd0);
      check("t3_pc", pc, 32'd20);
      wait_done_drain("t3", 100);

      // out-of-range target clamps to PC_MAX
      redirect_to(32'd100, PC_MAX, 1'b1);
      check("t4_clamp", pc, PC_MAX);
      wait_done_drain("t4", 50);
`ifdef FETCH_STATS_EN
      check("t4_stats", fetch_count_o, 32'd1);
`endif

      // short async reset while stalled full
      redirect_to(32'd0, 32'd0, 1'b0);
      wait_cycles(20);
      check("t6_pc_hold", pc, 32'd4);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("t6_pc", pc, 32'd0);
      check("t6_valid", 32'(instr_valid_o), 32'd0);
      check("t6_instr", instr_o, 32'd0);
      check("t6_tag", instr_pc_o, 32'd0);
      check("t6_done", 32'(done_o), 32'd0);
`ifdef FETCH_STATS_EN
      check("t6_stats", fetch_count_o, 32'd0);
`endif
      rst_n = 1'b1;
      expect_run(32'd0);
      instr_ready_i = 1'b1;
      wait_done_drain("t6", 200);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/m_fetch_queue.md
M_FETCH_QUEUE -- requirements
Module: m_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; SHALL be a power of two in 2..16.
REQ-002 Parameter PC_MAX, default 32'd400, last valid word index; fetch SHALL NOT issue pc above it.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 enable_i  input  1  fetch run request.
REQ-006 pc  output  32  word index driven to the decompressor.
REQ-007 instruction  input  32  expanded instruction returned by the decompressor for pc.
REQ-008 redirect_i  input  1  branch/jump redirect strobe.
REQ-009 redirect_pc_i  input  32  redirect target word index.
REQ-010 instr_o  output  32  head-of-queue instruction.
REQ-011 instr_pc_o  output  32  word index tag of instr_o.
REQ-012 instr_valid_o  output  1  queue non-empty.
REQ-013 instr_ready_i  input  1  consumer accepts head when high with instr_valid_o.
REQ-014 done_o  output  1  pc reached PC_MAX and its word was captured.

Function
REQ-015 FSM states SHALL be S_IDLE, S_ISSUE, S_CAPTURE, S_FULL, S_DONE.
REQ-016 S_IDLE: enable_i=1 -> S_ISSUE; otherwise hold.
REQ-017 S_ISSUE: pc held stable one cycle for the decompressor to settle -> S_CAPTURE.
REQ-018 S_CAPTURE: if queue has space (or a pop occurs the same cycle) SHALL push {instruction, pc}; then pc==PC_MAX -> S_DONE, else pc+1 and -> S_ISSUE (enable_i=1) or S_IDLE (enable_i=0); if no space -> S_FULL with pc held.
REQ-019 S_FULL: hold pc; on first cycle with space SHALL push and advance as in S_CAPTURE.
REQ-020 S_DONE: done_o=1, no pushes; leaves only via redirect or reset.
REQ-021 Peak throughput SHALL be one push per two cycles; pc SHALL never change while in S_CAPTURE or S_FULL except by redirect.
REQ-022 Pop SHALL occur when instr_valid_o && instr_ready_i; instr_o/instr_pc_o SHALL be registered head outputs, valid the same cycle instr_valid_o is high.
REQ-023 Simultaneous push and pop when full SHALL both succeed, count unchanged; when empty, pushed entry SHALL appear on instr_o the next cycle.
REQ-024 redirect_i SHALL take priority over push and pop: queue flushed (count=0), pc=redirect_pc_i, done_o=0, next state S_ISSUE.
REQ-025 redirect_pc_i > PC_MAX SHALL be clamped to PC_MAX.
REQ-026 Read/write pointers SHALL be log2(DEPTH) bits, wrapping modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.

Reset
REQ-027 rst_n=0 SHALL asynchronously force: state S_IDLE, pc=0, pointers and count 0, instr_valid_o=0, instr_o=0, instr_pc_o=0, done_o=0.
REQ-028 Reset mid-fetch SHALL discard queued entries and any in-flight capture; fetch restarts at pc=0.

Configuration
REQ-029 Macro FETCH_STATS_EN defined: SHALL add output fetch_count_o (32 bits, reset 0) counting pushes, saturating at 32'hFFFFFFFF, cleared on redirect; undefined: port and counter SHALL be absent, all other behaviour identical.

Structure
REQ-030 Package m_fetch_pkg SHALL hold the state enum type, the 32-bit word-index typedef, and the queue entry struct {instruction, pc}.
REQ-031 One sub-module m_fetch_fifo (DEPTH-entry sync FIFO with flush) SHALL hold the queue storage; FSM and pc logic stay in m_fetch_queue.

Verification
REQ-032 Reset, enable_i=1, instr_ready_i=1, decompressor model returns 32'hA000_0000+pc -> instr_o sequence A0000000, A0000001, A0000002 with instr_pc_o 0,1,2, one per two cycles.
REQ-033 instr_ready_i=0 with DEPTH=4 -> four pushes, state S_FULL, pc stays 4; raise ready -> pc 5 two cycles after first pop.
REQ-034 Queue full, then redirect_i=1 with redirect_pc_i=32'd20 and ready=1 same cycle -> no pop, instr_valid_o=0 next cycle, first new entry tagged 20.
REQ-035 PC_MAX=5 run -> last entry tagged 5, done_o=1, no further pushes; redirect to 2 -> done_o=0, fetch resumes at 2.
REQ-036 rst_n pulsed low for 1 ns mid-S_FULL -> outputs zero immediately, restart fetch at pc=0; with FETCH_STATS_EN, fetch_count_o returns to 0.
